// File: rtl/ahb_master_decoder_pmap_pkg.sv
// AHB_package: shared AHB transfer types and the per-master decoder state encoding
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    HSIZE_8    = 3'b000,
    HSIZE_16   = 3'b001,
    HSIZE_32   = 3'b010,
    HSIZE_64   = 3'b011,
    HSIZE_128  = 3'b100,
    HSIZE_256  = 3'b101,
    HSIZE_512  = 3'b110,
    HSIZE_1024 = 3'b111
  } hsize_type;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SLVSEL = 2'b01,
    ST_ERROR  = 2'b10
  } ahb_dec_state_e;

endpackage

// File: rtl/ahb_master_decoder_pmap_match.sv
// ahb_addr_range_match: inclusive address window compare with optional remap window
module ahb_addr_range_match #(
  parameter int                        AHB_ADDR_WIDTH = 32,
  parameter logic [AHB_ADDR_WIDTH-1:0] LOW            = '0,
  parameter logic [AHB_ADDR_WIDTH-1:0] HIGH           = '0,
  parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_LOW      = '0,
  parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_HIGH     = '0
) (
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic                      use_remap,
  output logic                      hit
);

  assign hit = use_remap ? (haddr >= REMAP_LOW && haddr <= REMAP_HIGH)
                         : (haddr >= LOW && haddr <= HIGH);

endmodule

// File: rtl/ahb_master_decoder_pmap.sv
// ahb_master_decoder_pmap: per-master AHB address decoder holding a one-hot request until granted
module ahb_master_decoder_pmap
  import AHB_package::*;
#(
  parameter int                                       AHB_ADDR_WIDTH = 32,
  parameter int                                       SLAVE_NUM      = 4,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR       = '0,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR      = '0,
  parameter bit                                       REMAP_EN       = 1'b0,
  parameter int                                       REMAP_SLAVE    = 0,
  parameter logic [AHB_ADDR_WIDTH-1:0]                REMAP_LOW      = '0,
  parameter logic [AHB_ADDR_WIDTH-1:0]                REMAP_HIGH     = '0,
  parameter bit                                       OUT_REG        = 1'b1
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  hsize_type                 hsize,
  input  logic                      hready,
  input  logic                      hremap,
  input  logic [SLAVE_NUM-1:0]      hgrant,
  output logic [SLAVE_NUM-1:0]      hreq,
  output logic                      default_slv_sel,
  output logic [7:0]                dec_err_cnt
);

  ahb_dec_state_e       state, state_d;
  logic [SLAVE_NUM-1:0] raw_hit, hit, sel_q, sel_d;
  logic                 dec_ev, granted, go_idle, do_dec, miss;
  logic                 unused_size;

  assign unused_size = &{1'b0, hsize};

  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_match
    ahb_addr_range_match #(
      .AHB_ADDR_WIDTH(AHB_ADDR_WIDTH),
      .LOW           (LOW_ADDR[i]),
      .HIGH          (HIGH_ADDR[i]),
      .REMAP_LOW     (REMAP_LOW),
      .REMAP_HIGH    (REMAP_HIGH)
    ) u_match (
      .haddr    (haddr),
      .use_remap(REMAP_EN && (i == REMAP_SLAVE) && hremap),
      .hit      (raw_hit[i])
    );
  end

  // Overlapping windows resolve to the lowest index so the request stays one-hot.
  assign hit = raw_hit & (~raw_hit + SLAVE_NUM'(1));

  assign dec_ev  = hready && (htrans == HTRANS_NONSEQ ||
                   (htrans == HTRANS_SEQ && (state == ST_IDLE || haddr[9:0] == 10'd0)));
  assign granted = |(hgrant & sel_q);
  assign go_idle = hready && htrans == HTRANS_IDLE &&
                   (state == ST_ERROR || (state == ST_SLVSEL && granted));
  assign do_dec  = dec_ev && (state != ST_SLVSEL || granted);

  // Next state: a pending ungranted request ignores the bus; otherwise return to idle or re-decode.
  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    miss    = 1'b0;
    if (go_idle) state_d = ST_IDLE;
    else if (do_dec) begin
      state_d = |hit ? ST_SLVSEL : ST_ERROR;
      sel_d   = |hit ? hit : sel_q;
      miss    = ~|hit;
    end
  end

  // State, selection and saturating miss counter.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      dec_err_cnt <= '0;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
      if (miss && dec_err_cnt != 8'hFF) dec_err_cnt <= dec_err_cnt + 8'd1;
    end
  end

  assign hreq            = OUT_REG ? (state == ST_SLVSEL ? sel_q : '0)
                                   : (state_d == ST_SLVSEL ? sel_d : '0);
  assign default_slv_sel = OUT_REG ? state == ST_ERROR : state_d == ST_ERROR;

endmodule

// File: tb/tb_ahb_master_decoder_pmap.sv
// tb_ahb_master_decoder_pmap: scoreboard bench with a behavioural decode model
module tb_ahb_master_decoder_pmap;
  import AHB_package::*;

  typedef struct {
    logic [1:0] hreq;
    logic       dflt;
    logic [7:0] cnt;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset_n = 1'b0;
  logic [31:0] haddr = '0;
  htrans_type  htrans = HTRANS_IDLE;
  hsize_type   hsize = HSIZE_32;
  logic        hready = 1'b1;
  logic        hremap = 1'b0;
  logic [1:0]  hgrant = '0;
  logic [1:0]  hreq;
  logic        default_slv_sel;
  logic [7:0]  dec_err_cnt;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: where the master is currently pointed (-2 nowhere, -1 default slave, k slave k).
  int   m_tgt = -2;
  int   m_cnt = 0;

  ahb_master_decoder_pmap #(
    .AHB_ADDR_WIDTH(32),
    .SLAVE_NUM     (2),
    .LOW_ADDR      ({32'h0000_2400, 32'h0000_2000}),
    .HIGH_ADDR     ({32'h0000_24FF, 32'h0000_23FF}),
    .REMAP_EN      (1'b1),
    .REMAP_SLAVE   (0),
    .REMAP_LOW     (32'h0000_0000),
    .REMAP_HIGH    (32'h0000_03FF),
    .OUT_REG       (1'b1)
  ) dut (
    .hclk           (hclk),
    .hreset_n       (hreset_n),
    .haddr          (haddr),
    .htrans         (htrans),
    .hsize          (hsize),
    .hready         (hready),
    .hremap         (hremap),
    .hgrant         (hgrant),
    .hreq           (hreq),
    .default_slv_sel(default_slv_sel),
    .dec_err_cnt    (dec_err_cnt)
  );

  always #5 hclk = ~hclk;

  function automatic int lookup(input logic [31:0] a, input logic rm);
    int lo[2];
    int hi[2];
    lo[0] = rm ? 32'h0000 : 32'h2000;
    hi[0] = rm ? 32'h03FF : 32'h23FF;
    lo[1] = 32'h2400;
    hi[1] = 32'h24FF;
    for (int k = 0; k < 2; k++) if (a >= lo[k] && a <= hi[k]) return k;
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.hreq = m_tgt >= 0 ? 2'(1 << m_tgt) : 2'b00;
    e.dflt = m_tgt == -1;
    e.cnt  = 8'(m_cnt);
    return e;
  endfunction

  task automatic model_step();
    int  h;
    bit  newdec;
    if (!hready) return;
    if (m_tgt >= 0 && !hgrant[m_tgt]) return;
    newdec = htrans == HTRANS_NONSEQ ||
             (htrans == HTRANS_SEQ && (m_tgt == -2 || haddr[9:0] == 10'd0));
    if (htrans == HTRANS_IDLE) m_tgt = -2;
    else if (newdec) begin
      h = lookup(haddr, hremap);
      m_tgt = h;
      if (h < 0 && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic cyc(input logic [31:0] a, input htrans_type t, input logic [1:0] g,
                     input logic rm, input logic rdy);
    @(negedge hclk);
    hreset_n = 1'b1;
    haddr = a; htrans = t; hgrant = g; hremap = rm; hready = rdy;
    hsize = hsize_type'($urandom_range(0, 7));
    model_step();
    q.push_back(model_out());
  endtask

  task automatic rst_cycle();
    @(negedge hclk);
    hreset_n = 1'b0;
    htrans = HTRANS_IDLE;
    m_tgt = -2;
    m_cnt = 0;
    q.push_back(model_out());
  endtask

  task automatic async_rst();
    @(negedge hclk);
    #2 hreset_n = 1'b0;
    #1;
    total++;
    if (hreq !== 2'b00 || default_slv_sel !== 1'b0 || dec_err_cnt !== 8'h00) begin
      bad++;
      $display("FAIL async_reset got hreq=%b dflt=%b cnt=%0d want all zero",
               hreq, default_slv_sel, dec_err_cnt);
    end
    htrans = HTRANS_IDLE;
    m_tgt = -2;
    m_cnt = 0;
    q.push_back(model_out());
  endtask

  // Monitor: every cycle the decoder presents its outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (hreq !== e.hreq) begin
          bad++;
          $display("FAIL hreq t=%0t got=%b want=%b", $time, hreq, e.hreq);
        end
        total++;
        if (default_slv_sel !== e.dflt) begin
          bad++;
          $display("FAIL default_slv_sel t=%0t got=%b want=%b", $time, default_slv_sel, e.dflt);
        end
        total++;
        if (dec_err_cnt !== e.cnt) begin
          bad++;
          $display("FAIL dec_err_cnt t=%0t got=%0d want=%0d", $time, dec_err_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [31:0] pool[14];
    pool = '{32'h0000, 32'h0100, 32'h03FC, 32'h0400, 32'h1FFC, 32'h2000, 32'h2010,
             32'h23F8, 32'h23FC, 32'h2400, 32'h24FC, 32'h2500, 32'h2800, 32'h9000};
    rst_cycle();
    rst_cycle();
    cyc(32'h2010, HTRANS_NONSEQ, 2'b01, 1'b0, 1'b1);
    cyc(32'h2010, HTRANS_IDLE, 2'b01, 1'b0, 1'b1);
    cyc(32'h0000, HTRANS_IDLE, 2'b00, 1'b0, 1'b1);
    cyc(32'h2400, HTRANS_NONSEQ, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(32'h3000, HTRANS_NONSEQ, 2'b00, 1'b0, 1'b1);
    cyc(32'h3000, HTRANS_IDLE, 2'b10, 1'b0, 1'b1);
    cyc(32'h9000, HTRANS_NONSEQ, 2'b00, 1'b0, 1'b1);
    cyc(32'h2000, HTRANS_NONSEQ, 2'b00, 1'b0, 1'b1);
    cyc(32'h2000, HTRANS_IDLE, 2'b01, 1'b0, 1'b1);
    cyc(32'h23F0, HTRANS_NONSEQ, 2'b01, 1'b0, 1'b1);
    cyc(32'h23F8, HTRANS_SEQ, 2'b01, 1'b0, 1'b1);
    cyc(32'h23FC, HTRANS_SEQ, 2'b01, 1'b0, 1'b1);
    cyc(32'h2400, HTRANS_SEQ, 2'b01, 1'b0, 1'b1);
    cyc(32'h2404, HTRANS_SEQ, 2'b10, 1'b0, 1'b1);
    cyc(32'h2404, HTRANS_IDLE, 2'b10, 1'b0, 1'b1);
    cyc(32'h0100, HTRANS_NONSEQ, 2'b01, 1'b1, 1'b1);
    cyc(32'h0100, HTRANS_IDLE, 2'b01, 1'b1, 1'b1);
    cyc(32'h0100, HTRANS_NONSEQ, 2'b00, 1'b0, 1'b1);
    cyc(32'h0100, HTRANS_IDLE, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cyc(32'h9000 + 32'(4 * i), HTRANS_NONSEQ, 2'b00, 1'b0, 1'b1);
    cyc(32'h9000, HTRANS_NONSEQ, 2'b00, 1'b0, 1'b0);
    cyc(32'h2000, HTRANS_NONSEQ, 2'b00, 1'b0, 1'b1);
    cyc(32'h2004, HTRANS_SEQ, 2'b00, 1'b0, 1'b1);
    async_rst();
    cyc(32'h0000, HTRANS_IDLE, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 3) == 0 ? ($urandom() & 32'h0000_FFFC) : pool[$urandom_range(0, 13)];
      if (i == 300) async_rst();
      cyc(a, htrans_type'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
    end
    cyc(32'h0000, HTRANS_IDLE, 2'b11, 1'b0, 1'b1);
    repeat (3) @(posedge hclk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_decoder_pmap.md
# ahb_master_decoder_pmap

Parameterised per-master AHB address decoder for the generated interconnect, one instance per master port. It decodes each valid address phase against a parameter-supplied slave address map, with an optional remap window. It holds a one-hot request toward the matrix arbiters until granted, and routes unmapped accesses to the default slave. It also re-decodes bursts that cross a 1 KB boundary and counts decode errors.

## Interface
- AHB_ADDR_WIDTH, 32, address width.
- SLAVE_NUM, 4, number of slaves reachable from this master (≥1).
- LOW_ADDR, all zero, packed [SLAVE_NUM][AHB_ADDR_WIDTH] inclusive low bound per slave.
- HIGH_ADDR, all zero, packed [SLAVE_NUM][AHB_ADDR_WIDTH] inclusive high bound per slave.
- REMAP_EN, 0, enables the remap window.
- REMAP_SLAVE, 0, slave index that uses the remap window when hremap=1.
- REMAP_LOW / REMAP_HIGH, 0 / 0, inclusive remap window bounds.
- OUT_REG, 1, 1 = registered (glitch-free) hreq/default_slv_sel; 0 = combinational.
- hclk, input, 1, bus clock.
- hreset_n, input, 1, asynchronous active-low reset.
- haddr, input, AHB_ADDR_WIDTH, master address.
- htrans, input, htrans_type, transfer type.
- hsize, input, hsize_type, transfer size (carried for monitors; decode is size-independent).
- hready, input, 1, bus ready; address phase is valid only when hready=1.
- hremap, input, 1, remap select.
- hgrant, input, SLAVE_NUM, per-slave grant from arbiters.
- hreq, output, SLAVE_NUM, one-hot slave request.
- default_slv_sel, output, 1, default (error) slave select.
- dec_err_cnt, output, 8, saturating count of decode misses.

## Operation
- Hit: slave i hits when LOW_ADDR[i] ≤ haddr ≤ HIGH_ADDR[i]. For i=REMAP_SLAVE with REMAP_EN=1 and hremap=1, the remap window replaces the normal window. If windows overlap, the lowest index wins, so hit is always one-hot. Miss = no hit.
- Decode event: hready=1 and one of the following:
  - htrans=NONSEQ in any state.
  - htrans=SEQ in IDLE.
  - htrans=SEQ with haddr[9:0]==0 (1 KB crossing).
- FSM states IDLE, SLVSEL, ERROR; registered one-hot sel_q.
- IDLE:
  - decode hit → sel_q ← hit, go SLVSEL.
  - miss → go ERROR, dec_err_cnt+1.
  - IDLE/BUSY → stay.
- SLVSEL (hreq = sel_q):
  - If (hgrant & sel_q)==0 (waiting), hold state and sel_q; ignore all inputs.
  - Granted, hready=1, htrans=IDLE → go IDLE.
  - Granted, decode event: hit → reload sel_q and stay; miss → go ERROR, count+1.
  - Granted, SEQ/BUSY with no decode event → hold.
- ERROR (default_slv_sel = 1):
  - hready=1, htrans=IDLE → go IDLE.
  - Decode event: hit → go SLVSEL; miss → stay, count+1.
- hready=0 freezes state, sel_q and counter.
- dec_err_cnt saturates at 8'hFF.
- hreq and default_slv_sel are never both asserted; hreq is never multi-hot.

## Timing
- Reset values: state IDLE, sel_q=0, hreq=0, default_slv_sel=0, dec_err_cnt=0. Reset acts asynchronously, including mid-burst or while waiting for grant.
- OUT_REG=1: outputs derive from registered state/sel_q, so hreq/default_slv_sel rise one cycle after the sampled address phase.
- OUT_REG=0: outputs derive from next-state values combinationally, giving zero latency.
- dec_err_cnt is registered and updates one cycle after the miss in both modes.
- Simultaneous grant and new NONSEQ: the new decode takes effect; the old request drops in the same cycle the new one rises, with no idle gap.

## Structure
- htrans_type and hsize_type come from AHB_package.
- Add the state enum ahb_dec_state_e to AHB_package.
- One sub-module, ahb_addr_range_match: per-slave inclusive range compare plus remap mux, instantiated in a generate loop.
- Priority one-hot encoding and the FSM live in the top module.

## Test plan
Default map for all tests: SLAVE_NUM=2, OUT_REG=1, slave0 0x2000–0x23FF, slave1 0x2400–0x24FF, REMAP_EN=1, REMAP_SLAVE=0, remap window 0x0000–0x03FF.
- NONSEQ 0x2010 with hgrant=2'b01 → next cycle hreq=2'b01. Then htrans=IDLE → hreq=0 one cycle later.
- NONSEQ 0x2400 with hgrant=0 for 3 cycles while haddr changes to 0x3000 → hreq holds 2'b10 throughout and dec_err_cnt stays 0.
- NONSEQ 0x9000 → default_slv_sel=1 and dec_err_cnt=1. Then NONSEQ 0x2000 → hreq=2'b01 and default_slv_sel=0.
- INCR burst granted on slave0: SEQ beats 0x23F8, 0x23FC, 0x2400 → hreq switches to 2'b10 on the 0x2400 beat (plus one cycle).
- hremap=1, NONSEQ 0x0100 → hreq=2'b01. With hremap=0 the same access → default_slv_sel=1.
- 300 consecutive miss NONSEQs → dec_err_cnt=8'hFF. Assert hreset_n=0 mid-transfer → all outputs 0 immediately.
